counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencing controller that wraps the team's 4-bit up-counter datapath, turning it into a programmable interval timer.
- Features: start/stop/pause control, a prescaler, a programmable terminal count, and one-shot or auto-reload modes.
- Emits a one-cycle terminal-count pulse (tc) for downstream logic; also serves as the standard timer primitive for testbench-driven behavioural experiments.

Parameters:
WIDTH, 4, width of count value q and terminal input
PRE_W, 4, width of prescale input and internal prescale counter

Ports:
clk  input  1  single clock, all logic on rising edge
rst  input  1  reset, synchronous, active-high; clears all state on the next clk edge
start  input  1  start/restart request, sampled each clock
stop  input  1  abort request, sampled each clock
pause  input  1  level; freezes counting while high in RUN/HOLD
mode  input  1  0 = one-shot, 1 = auto-reload; latched on accepted start
terminal  input  WIDTH  terminal count value; latched on accepted start
prescale  input  PRE_W  q advances once every prescale+1 clocks; latched on accepted start
q  output  WIDTH  current count (registered)
tc  output  1  one-cycle pulse, registered, on terminal tick
busy  output  1  high in RUN or HOLD
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, q=0, tc=0, busy=0, prescale counter pre_cnt=0, latched config registers cleared. rst overrides every other input.
- Input priority each edge: rst > stop > start > pause.
- Internal tick: in RUN only. tick = (pre_cnt == pre_r). On a tick, pre_cnt<=0; otherwise pre_cnt<=pre_cnt+1. With prescale=0, there is a tick every cycle.
- IDLE:
  - start -> RUN; q<=0, pre_cnt<=0; latch mode_r/term_r/pre_r.
  - stop and pause are ignored.
- RUN:
  - stop -> IDLE, q<=0, pre_cnt<=0.
  - start -> restart exactly as from IDLE (relatch config, q<=0); any tick that cycle is discarded.
  - pause (no stop/start) -> HOLD; q and pre_cnt frozen; no tick consumed.
  - tick with q!=term_r -> q<=q+1.
  - tick with q==term_r -> tc<=1 for one cycle, then:
    - mode_r=1: q<=0, stay RUN.
    - mode_r=0: q holds term_r, go DONE.
- HOLD:
  - stop -> IDLE (q<=0).
  - start -> restart.
  - pause low -> RUN; counting resumes from frozen pre_cnt/q on the following cycle.
- DONE:
  - q holds term_r, busy=0.
  - start -> restart.
  - stop -> IDLE, q<=0.
- tc defaults to 0 every cycle it is not set. It is never asserted in IDLE/HOLD/DONE except as the registered pulse of the transition edge.
- Latency:
  - start accepted at edge N -> state=RUN, q=0 after edge N.
  - With prescale=0: q=1 after edge N+1; terminal period = (term_r+1)*(prescale+1) clocks.
- Boundaries:
  - term_r=0: tc every tick, q stays 0 (auto-reload), or DONE after first tick (one-shot).
  - term_r=2^WIDTH-1: full wrap 15->0 in auto-reload; no overflow beyond WIDTH bits.
  - terminal/prescale/mode changes while busy have no effect until the next accepted start.
  - start and stop together: stop wins, go IDLE.
  - rst mid-RUN: IDLE, q=0 on the same edge; tc dropped even if a tick coincides.

Test Plan:
- Reset then idle: rst=1 two cycles, release; hold start=0 for 20 cycles -> q=0, tc=0, busy=0, state=00 throughout.
- Auto-reload, prescale=0, terminal=3, start pulse -> q cycles 0,1,2,3,0,...; tc=1 exactly in cycles where q returns to 0, every 4 clocks; busy=1 continuously.
- One-shot, prescale=2, terminal=5, start pulse -> q increments every 3 clocks; tc=1 once, 18 clocks after the start edge; state=11; q holds 5; busy=0.
- Pause/stop: auto-reload, terminal=15, prescale=0; pause high at q=7 for 10 cycles -> q stays 7, state=10; release -> q=8 next cycle; stop at q=12 -> q=0, state=00.
- Simultaneous and boundary: start+stop same cycle in RUN -> IDLE; terminal=0 auto-reload -> tc every cycle; rst asserted on the tc tick -> tc=0, q=0.
- Config isolation: change terminal 3->9 mid-RUN -> period stays 4 until a new start, then becomes 10.

Source files
------------

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
//
// Purpose:
//   Programmable interval timer built around a WIDTH-bit up-counter. A
//   prescaler divides the clock so that the count value advances once every
//   (prescale+1) clocks. On reaching the terminal count the block emits a
//   one-cycle terminal-count pulse (tc). In auto-reload mode it then wraps to
//   zero and keeps running. In one-shot mode it parks in DONE holding the
//   terminal value.
//
// Ports:
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset, overrides every other input
//   start    in   start / restart request (latches mode, terminal, prescale)
//   stop     in   abort request, returns to IDLE (wins over start)
//   pause    in   level, freezes counting while high in RUN/HOLD
//   mode     in   0 = one-shot, 1 = auto-reload
//   terminal in   terminal count value [WIDTH-1:0]
//   prescale in   prescale value [PRE_W-1:0]
//   q        out  current count (registered)
//   tc       out  one-cycle terminal-count pulse (registered)
//   busy     out  high in RUN or HOLD (registered)
//   state    out  IDLE=00, RUN=01, HOLD=10, DONE=11 (registered)
// -----------------------------------------------------------------------------
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] terminal,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10,
    ST_DONE = 2'b11
  } state_e;

  // Registered state
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;

  // Configuration latched on an accepted start
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [PRE_W-1:0] pre_q, pre_d;

  // Prescaler tick: only meaningful while actually counting in RUN
  logic tick;

  // Prescaler tick decode
  always_comb begin
    tick = 1'b0;
    if (state_q == ST_RUN) begin
      tick = (pre_cnt_q == pre_q);
    end else begin
      tick = 1'b0;
    end
  end

  // Next-state, count and pulse logic; priority is stop > start > pause > tick
  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    pre_cnt_d = pre_cnt_q;
    tc_d      = 1'b0;
    mode_d    = mode_q;
    term_d    = term_q;
    pre_d     = pre_q;

    if (stop) begin
      // In IDLE q and pre_cnt are already zero, so this is a no-op there.
      state_d   = ST_IDLE;
      q_d       = {WIDTH{1'b0}};
      pre_cnt_d = {PRE_W{1'b0}};
    end else if (start) begin
      // Start or restart from any state; a tick in this cycle is discarded.
      state_d   = ST_RUN;
      q_d       = {WIDTH{1'b0}};
      pre_cnt_d = {PRE_W{1'b0}};
      mode_d    = mode;
      term_d    = terminal;
      pre_d     = prescale;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (pause) begin
            // Freeze q and pre_cnt; the pending tick is not consumed.
            state_d = ST_HOLD;
          end else if (tick) begin
            pre_cnt_d = {PRE_W{1'b0}};
            if (q_q == term_q) begin
              tc_d = 1'b1;
              if (mode_q) begin
                q_d = {WIDTH{1'b0}};
              end else begin
                // One-shot: q keeps the terminal value while parked.
                state_d = ST_DONE;
              end
            end else begin
              q_d = q_q + WIDTH'(1);
            end
          end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
          end
        end
        ST_HOLD: begin
          // Resume on the edge pause is seen low; counting restarts next cycle.
          if (!pause) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HOLD;
          end
        end
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d   = ST_IDLE;
          q_d       = {WIDTH{1'b0}};
          pre_cnt_d = {PRE_W{1'b0}};
        end
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      q_q       <= {WIDTH{1'b0}};
      pre_cnt_q <= {PRE_W{1'b0}};
      tc_q      <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      term_q    <= {WIDTH{1'b0}};
      pre_q     <= {PRE_W{1'b0}};
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      pre_cnt_q <= pre_cnt_d;
      tc_q      <= tc_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      term_q    <= term_d;
      pre_q     <= pre_d;
    end
  end

  assign q     = q_q;
  assign tc    = tc_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_counter_seq_ctrl
//
// Self-checking bench for counter_seq_ctrl. The reference model tracks only
// the phase (idle/run/hold/done), the latched configuration and the number of
// counting clocks k since the last start. The count is derived arithmetically:
//   q  = (k / (pre+1)) mod (term+1)
//   tc fires when k is a multiple of (pre+1)*(term+1)
// Directed scenarios carry hand-computed literal checks as well.
// -----------------------------------------------------------------------------
module tb_counter_seq_ctrl;

  localparam int WIDTH = 4;
  localparam int PRE_W = 4;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] terminal;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .terminal (terminal),
    .prescale (prescale),
    .q        (q),
    .tc       (tc),
    .busy     (busy),
    .state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 idle, 1 run, 2 hold, 3 done
  int m_phase = 0;
  int m_k     = 0;
  int m_mode  = 0;
  int m_term  = 0;
  int m_pre   = 0;
  int m_tc    = 0;
  bit m_valid = 1'b0;

  always @(posedge clk) begin
    m_tc <= 0;
    if (rst) begin
      m_phase <= 0;
      m_k     <= 0;
      m_mode  <= 0;
      m_term  <= 0;
      m_pre   <= 0;
      m_valid <= 1'b1;
    end else if (stop) begin
      m_phase <= 0;
      m_k     <= 0;
    end else if (start) begin
      m_phase <= 1;
      m_k     <= 0;
      m_mode  <= int'(mode);
      m_term  <= int'(terminal);
      m_pre   <= int'(prescale);
    end else if (m_phase == 1) begin
      if (pause) begin
        m_phase <= 2;
      end else begin
        m_k <= m_k + 1;
        if (((m_k + 1) % ((m_pre + 1) * (m_term + 1))) == 0) begin
          m_tc <= 1;
          if (m_mode == 0) m_phase <= 3;
        end
      end
    end else if (m_phase == 2 && !pause) begin
      m_phase <= 1;
    end
  end

  function automatic int exp_q();
    if (m_phase == 0) return 0;
    if (m_phase == 3) return m_term;
    return (m_k / (m_pre + 1)) % (m_term + 1);
  endfunction

  // Single compare process: DUT vs model on every falling edge
  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), exp_q());
      check("model_tc", int'(tc), m_tc);
      check("model_busy", int'(busy), (m_phase == 1 || m_phase == 2) ? 1 : 0);
      check("model_state", int'(state), m_phase);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_start(input logic md, input int term, input int pre);
    mode     = md;
    terminal = WIDTH'(term);
    prescale = PRE_W'(pre);
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 1'b0; terminal = '0; prescale = '0;

    // Reset then idle
    steps(2);
    rst = 1'b0;
    check("rst_q", int'(q), 0);
    check("rst_state", int'(state), 0);
    pause = 1'b1; stop = 1'b1;
    steps(10);
    pause = 1'b0; stop = 1'b0;
    steps(10);
    check("idle_q", int'(q), 0);
    check("idle_busy", int'(busy), 0);

    // Auto-reload, prescale 0, terminal 3
    do_start(1'b1, 3, 0);
    check("ar_q0", int'(q), 0);
    check("ar_state", int'(state), 1);
    for (int i = 1; i <= 8; i++) begin
      step();
      check("ar_seq_q", int'(q), i % 4);
      check("ar_seq_tc", int'(tc), (i % 4 == 0) ? 1 : 0);
      check("ar_busy", int'(busy), 1);
    end

    // One-shot, prescale 2, terminal 5: tc 18 clocks after start
    do_start(1'b0, 5, 2);
    steps(3);
    check("os_q_after3", int'(q), 1);
    steps(14);
    check("os_tc_early", int'(tc), 0);
    check("os_q_17", int'(q), 5);
    step();
    check("os_tc18", int'(tc), 1);
    check("os_state", int'(state), 3);
    check("os_q_hold", int'(q), 5);
    check("os_busy", int'(busy), 0);
    step();
    check("os_tc_once", int'(tc), 0);
    pause = 1'b1; steps(3); pause = 1'b0;
    check("os_done_stays", int'(state), 3);

    // Pause / stop
    do_start(1'b1, 15, 0);
    steps(7);
    check("ps_q7", int'(q), 7);
    pause = 1'b1;
    step();
    check("ps_hold_state", int'(state), 2);
    steps(9);
    check("ps_hold_q", int'(q), 7);
    pause = 1'b0;
    step();
    check("ps_resume_state", int'(state), 1);
    step();
    check("ps_q8", int'(q), 8);
    steps(4);
    check("ps_q12", int'(q), 12);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("ps_stop_q", int'(q), 0);
    check("ps_stop_state", int'(state), 0);

    // Full wrap at terminal 15
    do_start(1'b1, 15, 0);
    steps(16);
    check("wrap_q", int'(q), 0);
    check("wrap_tc", int'(tc), 1);

    // start + stop together in RUN: stop wins
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_state", int'(state), 0);

    // terminal 0 auto-reload: tc every cycle
    do_start(1'b1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t0_tc", int'(tc), 1);
      check("t0_q", int'(q), 0);
    end

    // rst on the tc tick
    do_start(1'b1, 3, 0);
    steps(3);
    check("rt_q3", int'(q), 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rt_tc", int'(tc), 0);
    check("rt_q", int'(q), 0);
    check("rt_state", int'(state), 0);

    // Config isolation
    do_start(1'b1, 3, 0);
    terminal = 4'd9; prescale = 4'd7; mode = 1'b0;
    steps(4);
    check("ci_tc4", int'(tc), 1);
    check("ci_q4", int'(q), 0);
    do_start(1'b1, 9, 0);
    steps(9);
    check("ci_q9", int'(q), 9);
    check("ci_tc9", int'(tc), 0);
    step();
    check("ci_tc10", int'(tc), 1);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      rst      = ($urandom_range(0, 199) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      start    = ($urandom_range(0, 24) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      mode     = 1'($urandom_range(0, 1));
      terminal = WIDTH'($urandom_range(0, 15));
      prescale = ($urandom_range(0, 3) == 0) ? PRE_W'($urandom_range(0, 15))
                                             : PRE_W'($urandom_range(0, 2));
      step();
    end
    rst = 1'b0; stop = 1'b0; start = 1'b0; pause = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
